// File: rtl/ddr_init_seq.sv
// DDR1 power-up initialisation sequencer with a runtime mode-register rewrite engine.
// Owns the command bus during init and during each requested MRS/EMRS update.
module ddr_init_seq #(
    parameter int                     BA_BITS   = 2,
    parameter int                     ROW_BITS  = 13,
    parameter int                     T_POWERUP = 40000,
    parameter int                     T_CKE     = 2,
    parameter int                     T_RP      = 3,
    parameter int                     T_MRD     = 2,
    parameter int                     T_RFC     = 15,
    parameter int                     T_DLL     = 200,
    parameter int                     N_REF     = 2,
    parameter logic [ROW_BITS-1:0]    EMR_VAL   = 'h000,
    parameter logic [ROW_BITS-1:0]    MR_VAL    = 'h022
) (
    input  logic                core_clk,
    input  logic                core_rst_sync,
    output logic                init_done,
    output logic                busy,
    input  logic                mode_req,
    input  logic [BA_BITS-1:0]  mode_ba,
    input  logic [ROW_BITS-1:0] mode_val,
    output logic                mode_ack,
    output logic                ddr_cke,
    output logic                ddr_cs_n,
    output logic                ddr_ras_n,
    output logic                ddr_cas_n,
    output logic                ddr_we_n,
    output logic [BA_BITS-1:0]  ddr_ba,
    output logic [ROW_BITS-1:0] ddr_a
);

    function automatic int max2(int x, int y);
        return (x > y) ? x : y;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_CKE), max2(T_RP, T_MRD)),
                                max2(T_RFC, T_DLL));
    localparam int CW = $clog2(T_MAX) + 1;
    localparam int RW = $clog2(N_REF + 1);

    localparam logic [CW-1:0] RLD_CKE = CW'(T_CKE - 1);
    localparam logic [CW-1:0] RLD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] RLD_MRD = CW'(T_MRD - 1);
    localparam logic [CW-1:0] RLD_RFC = CW'(T_RFC - 1);
    localparam logic [CW-1:0] RLD_DLL = CW'(T_DLL - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(N_REF - 1);

    localparam logic [ROW_BITS-1:0] A10_BIT    = ROW_BITS'(1) << 10;
    localparam logic [ROW_BITS-1:0] A8_BIT     = ROW_BITS'(1) << 8;
    localparam logic [ROW_BITS-1:0] MR_DLL_RST = MR_VAL | A8_BIT;
    localparam logic [ROW_BITS-1:0] MR_NORM    = MR_VAL & ~A8_BIT;
    localparam logic [BA_BITS-1:0]  BA_EMR     = BA_BITS'(1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    typedef enum logic [3:0] {
        PWRUP, CKE_NOP, PRE1, EMRS, MRS_RST, PRE2, REF, MRS_NORM, IDLE, M_PRE, M_LOAD
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         ref_q, ref_d;
    logic                  cke_q, cke_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [BA_BITS-1:0]    ba_q, ba_d;
    logic [ROW_BITS-1:0]   a_q, a_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic [BA_BITS-1:0]    mba_q, mba_d;
    logic [ROW_BITS-1:0]   mval_q, mval_d;

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        ref_d   = ref_q;
        cke_d   = cke_q;
        cmd_d   = cke_q ? CMD_NOP : CMD_DESEL;
        ba_d    = '0;
        a_d     = '0;
        done_d  = done_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        mba_d   = mba_q;
        mval_d  = mval_q;

        unique case (state_q)
            PWRUP: if (cnt_zero) begin
                cke_d   = 1'b1;
                cmd_d   = CMD_NOP;
                cnt_d   = RLD_CKE;
                state_d = CKE_NOP;
            end
            CKE_NOP: if (cnt_zero) begin
                cmd_d   = CMD_PRE;
                a_d     = A10_BIT;
                cnt_d   = RLD_RP;
                state_d = PRE1;
            end
            PRE1: if (cnt_zero) begin
                cmd_d   = CMD_LMR;
                ba_d    = BA_EMR;
                a_d     = EMR_VAL;
                cnt_d   = RLD_MRD;
                state_d = EMRS;
            end
            EMRS: if (cnt_zero) begin
                cmd_d   = CMD_LMR;
                a_d     = MR_DLL_RST;
                cnt_d   = RLD_MRD;
                state_d = MRS_RST;
            end
            MRS_RST: if (cnt_zero) begin
                cmd_d   = CMD_PRE;
                a_d     = A10_BIT;
                cnt_d   = RLD_RP;
                state_d = PRE2;
            end
            PRE2: if (cnt_zero) begin
                cmd_d   = CMD_REF;
                cnt_d   = RLD_RFC;
                state_d = REF;
            end
            REF: if (cnt_zero) begin
                if (ref_q == REF_LAST) begin
                    cmd_d   = CMD_LMR;
                    a_d     = MR_NORM;
                    ref_d   = '0;
                    cnt_d   = RLD_DLL;
                    state_d = MRS_NORM;
                end else begin
                    cmd_d   = CMD_REF;
                    ref_d   = ref_q + RW'(1);
                    cnt_d   = RLD_RFC;
                end
            end
            MRS_NORM: if (cnt_zero) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            IDLE: if (mode_req && done_q) begin
                cmd_d   = CMD_PRE;
                a_d     = A10_BIT;
                busy_d  = 1'b1;
                mba_d   = mode_ba;
                mval_d  = mode_val;
                cnt_d   = RLD_RP;
                state_d = M_PRE;
            end
            M_PRE: if (cnt_zero) begin
                cmd_d   = CMD_LMR;
                ba_d    = mba_q;
                a_d     = mval_q;
                cnt_d   = RLD_MRD;
                state_d = M_LOAD;
            end
            M_LOAD: if (cnt_zero) begin
                busy_d  = 1'b0;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = PWRUP;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge core_clk) begin
        if (core_rst_sync) begin
            state_q <= PWRUP;
            cnt_q   <= CW'(T_POWERUP);  // CKE rises on the edge where this reaches zero
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DESEL;
            ba_q    <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // NOTE: captured request data is only read after a capture, so it carries no reset.
    always_ff @(posedge core_clk) begin
        mba_q  <= mba_d;
        mval_q <= mval_d;
    end

    assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = cmd_q;
    assign ddr_cke   = cke_q;
    assign ddr_ba    = ba_q;
    assign ddr_a     = a_q;
    assign init_done = done_q;
    assign busy      = busy_q;
    assign mode_ack  = ack_q;

endmodule

// File: doc/ddr_init_seq.md
Name: ddr_init_seq

Overview:
- Parametrised DDR1 power-up initialisation sequencer and mode-register update engine.
- Sits between the DDR controller core and the pad/PHY command bus, in the core_clk domain.
- Drives CKE and the command/address bus through the full JEDEC DDR1 init sequence, then raises init_done.
- Afterwards it accepts runtime mode/extended-mode register rewrites through a req/ack handshake; it owns the command bus only while busy.

Parameters:
- BA_BITS, 2, bank address width.
- ROW_BITS, 13, address bus width (must be >= 11).
- T_POWERUP, 40000, cycles CKE held low after reset release (200 us at 200 MHz).
- T_CKE, 2, cycles from CKE rise to first PRECHARGE ALL.
- T_RP, 3, PRECHARGE-to-next-command spacing in cycles.
- T_MRD, 2, LOAD MODE-to-next-command spacing in cycles.
- T_RFC, 15, AUTO REFRESH-to-next-command spacing in cycles.
- T_DLL, 200, cycles from final MRS to init_done.
- N_REF, 2, AUTO REFRESH commands issued during init (must be >= 2).
- EMR_VAL, 'h000, EMRS address value (DLL enable, normal drive).
- MR_VAL, 'h022, MRS address value (CL=2, BL=4, sequential); A8 is forced by the sequencer.

Ports:
- core_clk, in, 1, clock.
- core_rst_sync, in, 1, synchronous active-high reset.
- init_done, out, 1, init complete; stays high until reset.
- busy, out, 1, sequencer owns the command bus.
- mode_req, in, 1, request a mode register rewrite (level; sampled only in IDLE).
- mode_ba, in, BA_BITS, target register (0 = MR, 1 = EMR).
- mode_val, in, ROW_BITS, value to load.
- mode_ack, out, 1, one-cycle pulse when the rewrite is complete.
- ddr_cke, out, 1, clock enable.
- ddr_cs_n, out, 1, chip select.
- ddr_ras_n, out, 1, row address strobe.
- ddr_cas_n, out, 1, column address strobe.
- ddr_we_n, out, 1, write enable.
- ddr_ba, out, BA_BITS, bank address.
- ddr_a, out, ROW_BITS, address.

Behaviour:
- All outputs are registered.
- Reset values: ddr_cke=0, ddr_cs_n=1, ddr_ras_n/ddr_cas_n/ddr_we_n=1, ddr_ba=0, ddr_a=0, init_done=0, busy=1, mode_ack=0.
- Reset asserted in any state, including mid-sequence or mid-update, returns to PWRUP on the next edge.
- Command encodings, as {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111.
  - PRECHARGE ALL = 0010 with A10=1.
  - AUTO REFRESH = 0001.
  - LOAD MODE = 0000.
- Each command is present for exactly one cycle; NOP is driven in all other cycles after CKE rises.
- Cycle 0 is the first edge with reset low. Spacing below means cycles between command cycles.
- States and transitions:
  - PWRUP: CKE=0, cs_n=1 for T_POWERUP cycles; CKE=1 at cycle T_POWERUP.
  - CKE_NOP: NOP for T_CKE cycles.
  - PRE1: PRECHARGE ALL, then wait T_RP.
  - EMRS: LOAD MODE, ba=1, a=EMR_VAL; wait T_MRD.
  - MRS_RST: ba=0, a=MR_VAL with A8=1 (DLL reset); wait T_MRD.
  - PRE2: PRECHARGE ALL; wait T_RP.
  - REF: AUTO REFRESH then wait T_RFC, repeated N_REF times; a ref counter wraps to 0 on exit.
  - MRS_NORM: a=MR_VAL with A8=0; wait T_DLL.
  - IDLE: init_done=1 and busy=0 on the same edge, T_DLL cycles after MRS_NORM.
- A single down-counter, width $clog2(max T)+1, is reloaded with T-1 on each command. It advances on 0; T=1 means back-to-back commands.
- Mode update (IDLE only):
  - mode_req=1 sampled at cycle t gives busy=1 at t+1 and PRECHARGE ALL at t+1.
  - LOAD MODE with ba=mode_ba, a=mode_val follows at t+1+T_RP.
  - Return to IDLE at t+1+T_RP+T_MRD with mode_ack=1 for one cycle and busy=0.
  - mode_ba/mode_val are captured at t; later changes are ignored.
  - A mode_req still high on the ack cycle is not re-accepted until the next cycle.
  - mode_req is ignored while init_done=0.
- init_done never deasserts during a mode update.

Test Plan:
- Parameters for all scenarios: T_POWERUP=10, T_CKE=2, T_RP=3, T_MRD=2, T_RFC=8, T_DLL=20, N_REF=2.
- Init sequence -> CKE rises at cycle 10; commands appear at these cycles:
  - PRE at 12.
  - EMRS at 15 (ba=1, a=0x000).
  - MRS at 17 (ba=0, a=0x122).
  - PRE at 19.
  - REF at 22 and 30.
  - MRS at 38 (a=0x022).
  - init_done=1, busy=0 at cycle 58.
  - All non-command cycles after 10 are NOP.
- Reset check -> outputs hold reset values for every cycle of reset.
- Reset pulse at cycle 25, during the REF wait -> outputs return to reset values; the sequence restarts with CKE rise 10 cycles after release.
- mode_req at cycle 70 with mode_ba=0, mode_val=0x032 -> PRE at 71, LOAD MODE at 74 (ba=0, a=0x032), mode_ack pulse and busy=0 at 76; init_done stays 1.
- mode_req held high at cycle 30, before init_done -> no extra command; sequence timing identical to the init-sequence scenario.
- Counter boundary: T_RP=1 and T_MRD=1 -> PRE1, EMRS and MRS_RST occupy consecutive cycles.
- Ref-count check: N_REF=4 -> exactly four REF commands spaced 8 cycles apart.
